// File: rtl/processor_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes,
// ALU/PC select codes and the control-word bundle.
package processor_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_BRANCH = 2'd3;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdest;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  // First-level instruction dispatch out of DECODE; unknown opcodes trap.
  function automatic state_t dispatch(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_RTYPE:     nxt = S_EXEC;
      OP_LW, OP_SW: nxt = S_MEMADR;
      OP_BEQ:       nxt = S_BRANCH;
      OP_J:         nxt = S_JUMP;
      default:      nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// State-to-control decode for multicycle_ctrl. With MC_STALL_EN defined,
// memory-state write enables qualify on mem_ready.
module mc_decode
  import processor_pkg::*;
(
  input  state_t     state,
  input  logic       reset,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  logic  mem_ok;
  ctrl_t raw;

`ifdef MC_STALL_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  always_comb begin
    raw = '0;
    case (state)
      S_FETCH: begin
        raw.memread = 1'b1;
        raw.irwrite = mem_ok;
        raw.pcwrite = mem_ok;
        raw.alusrcb = SRCB_FOUR;
        raw.aluop   = ALUOP_ADD;
        raw.pcsource = PCSRC_ALU;
      end
      S_DECODE: begin
        raw.alusrcb = SRCB_BRANCH;
        raw.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        raw.alusrca = 1'b1;
        raw.alusrcb = SRCB_IMM;
        raw.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        raw.memread = 1'b1;
        raw.iord    = 1'b1;
      end
      S_MEMWB: begin
        raw.regwrite   = 1'b1;
        raw.memtoreg   = 1'b1;
        raw.instr_done = 1'b1;
      end
      // The write and the completion pulse both land in the ready cycle.
      S_MEMWR: begin
        raw.memwrite   = mem_ok;
        raw.iord       = 1'b1;
        raw.instr_done = mem_ok;
      end
      S_EXEC: begin
        raw.alusrca = 1'b1;
        raw.alusrcb = SRCB_REG;
        raw.aluop   = ALUOP_FUNCT;
      end
      S_RWB: begin
        raw.regwrite   = 1'b1;
        raw.regdest    = 1'b1;
        raw.instr_done = 1'b1;
      end
      S_BRANCH: begin
        raw.alusrca     = 1'b1;
        raw.alusrcb     = SRCB_REG;
        raw.aluop       = ALUOP_SUB;
        raw.pcwritecond = 1'b1;
        raw.pcsource    = PCSRC_ALUOUT;
        raw.instr_done  = 1'b1;
      end
      S_JUMP: begin
        raw.pcwrite    = 1'b1;
        raw.pcsource   = PCSRC_JUMP;
        raw.instr_done = 1'b1;
      end
      S_TRAP: begin
        raw.illegal = 1'b1;
      end
      default: begin
        raw = '0;
      end
    endcase
  end

  // While reset is held the state is already FETCH; only the writes are masked.
  always_comb begin
    ctrl = raw;
    if (reset) begin
      ctrl.pcwrite     = 1'b0;
      ctrl.pcwritecond = 1'b0;
      ctrl.memwrite    = 1'b0;
      ctrl.regwrite    = 1'b0;
      ctrl.irwrite     = 1'b0;
    end else begin
      ctrl = raw;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style main control FSM (Moore). Define MC_STALL_EN to hold
// FETCH/MEMRD/MEMWR until mem_ready.
module multicycle_ctrl
  import processor_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdest,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;
  logic   mem_ok;

`ifdef MC_STALL_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  // Opcode is consulted only in DECODE and MEMADR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: state_d = dispatch(opcode);
      S_MEMADR: begin
        if (opcode == OP_LW) begin
          state_d = S_MEMRD;
        end else if (opcode == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_MEMRD:  state_d = mem_ok ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ok ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  // State register; reset drops straight back to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  mc_decode u_decode (
    .state     (state_q),
    .reset     (reset),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pcwrite     = ctrl.pcwrite;
  assign pcwritecond = ctrl.pcwritecond;
  assign iord        = ctrl.iord;
  assign memread     = ctrl.memread;
  assign memwrite    = ctrl.memwrite;
  assign irwrite     = ctrl.irwrite;
  assign memtoreg    = ctrl.memtoreg;
  assign regdest     = ctrl.regdest;
  assign regwrite    = ctrl.regwrite;
  assign alusrca     = ctrl.alusrca;
  assign alusrcb     = ctrl.alusrcb;
  assign aluop       = ctrl.aluop;
  assign pcsource    = ctrl.pcsource;
  assign instr_done  = ctrl.instr_done;
  assign illegal     = ctrl.illegal;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed table-driven bench for multicycle_ctrl, plus trap, async-reset
// and mem_ready sequences (stall sequence under MC_STALL_EN).
module tb_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdest, regwrite, alusrca, instr_done, illegal;
  logic [1:0] alusrcb, aluop, pcsource;
  logic [3:0] state;

  int n_checks;
  int n_fail;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdest(regdest), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .pcsource(pcsource), .state(state), .instr_done(instr_done),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word order: pcwrite,pcwritecond,iord,memread,memwrite,irwrite,
  // memtoreg,regdest,regwrite,alusrca,alusrcb,aluop,pcsource,instr_done,illegal
  logic [17:0] ctl_w;
  assign ctl_w = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
                  memtoreg, regdest, regwrite, alusrca, alusrcb, aluop,
                  pcsource, instr_done, illegal};

  localparam logic [17:0] E_FETCH  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd1,2'd0,2'd0,1'b0,1'b0};
  localparam logic [17:0] E_RESET  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,2'd0,2'd0,1'b0,1'b0};
  localparam logic [17:0] E_DECODE = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,2'd0,2'd0,1'b0,1'b0};
  localparam logic [17:0] E_MEMADR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,2'd0,2'd0,1'b0,1'b0};
  localparam logic [17:0] E_MEMRD  = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,1'b0,1'b0};
  localparam logic [17:0] E_MEMWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,2'd0,2'd0,1'b1,1'b0};
  localparam logic [17:0] E_MEMWR  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,1'b1,1'b0};
  localparam logic [17:0] E_MEMWRW = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,1'b0,1'b0};
  localparam logic [17:0] E_EXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd2,2'd0,1'b0,1'b0};
  localparam logic [17:0] E_RWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd0,2'd0,2'd0,1'b1,1'b0};
  localparam logic [17:0] E_BRANCH = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd1,2'd1,1'b1,1'b0};
  localparam logic [17:0] E_JUMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd2,1'b1,1'b0};
  localparam logic [17:0] E_TRAP   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,1'b0,1'b1};

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] ctl;
  } vec_t;

  localparam int NV = 27;
  vec_t vt [NV];

  task automatic check(input string name, input logic [3:0] est, input logic [17:0] ectl);
    n_checks++;
    if (state !== est) begin
      n_fail++;
      $display("FAIL %s state: got %0d expected %0d", name, state, est);
    end
    n_checks++;
    if (ctl_w !== ectl) begin
      n_fail++;
      $display("FAIL %s ctrl: got %b expected %b", name, ctl_w, ectl);
    end
  endtask

  task automatic cyc(input string name, input logic r, input logic [5:0] op,
                     input logic rdy, input logic [3:0] est, input logic [17:0] ectl);
    @(negedge clk);
    reset = r;
    opcode = op;
    mem_ready = rdy;
    #2;
    check(name, est, ectl);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    opcode = 6'd0;
    mem_ready = 1'b1;

    vt[0]  = '{1'b1, LW,  1'b1, 4'd0,  E_RESET};
    vt[1]  = '{1'b0, LW,  1'b1, 4'd0,  E_FETCH};
    vt[2]  = '{1'b0, LW,  1'b1, 4'd1,  E_DECODE};
    vt[3]  = '{1'b0, LW,  1'b1, 4'd2,  E_MEMADR};
    vt[4]  = '{1'b0, LW,  1'b1, 4'd3,  E_MEMRD};
    vt[5]  = '{1'b0, LW,  1'b1, 4'd4,  E_MEMWB};
    vt[6]  = '{1'b0, RT,  1'b1, 4'd0,  E_FETCH};
    vt[7]  = '{1'b0, RT,  1'b1, 4'd1,  E_DECODE};
    vt[8]  = '{1'b0, RT,  1'b1, 4'd6,  E_EXEC};
    vt[9]  = '{1'b0, RT,  1'b1, 4'd7,  E_RWB};
    vt[10] = '{1'b0, BEQ, 1'b1, 4'd0,  E_FETCH};
    vt[11] = '{1'b0, BEQ, 1'b1, 4'd1,  E_DECODE};
    vt[12] = '{1'b0, BEQ, 1'b1, 4'd8,  E_BRANCH};
    vt[13] = '{1'b0, JMP, 1'b1, 4'd0,  E_FETCH};
    vt[14] = '{1'b0, JMP, 1'b1, 4'd1,  E_DECODE};
    vt[15] = '{1'b0, JMP, 1'b1, 4'd9,  E_JUMP};
    vt[16] = '{1'b0, SW,  1'b1, 4'd0,  E_FETCH};
    vt[17] = '{1'b0, SW,  1'b1, 4'd1,  E_DECODE};
    vt[18] = '{1'b0, SW,  1'b1, 4'd2,  E_MEMADR};
    vt[19] = '{1'b0, SW,  1'b1, 4'd5,  E_MEMWR};
    vt[20] = '{1'b0, RT,  1'b1, 4'd0,  E_FETCH};
    vt[21] = '{1'b0, RT,  1'b1, 4'd1,  E_DECODE};
    vt[22] = '{1'b0, BAD, 1'b1, 4'd6,  E_EXEC};
    vt[23] = '{1'b0, BAD, 1'b1, 4'd7,  E_RWB};
    vt[24] = '{1'b0, BAD, 1'b1, 4'd0,  E_FETCH};
    vt[25] = '{1'b0, BAD, 1'b1, 4'd1,  E_DECODE};
    vt[26] = '{1'b0, BAD, 1'b1, 4'd15, E_TRAP};

    for (int i = 0; i < NV; i++) begin
      cyc($sformatf("vec%0d", i), vt[i].rst, vt[i].op, vt[i].rdy, vt[i].st, vt[i].ctl);
    end

    // TRAP holds regardless of opcode until reset
    for (int i = 0; i < 10; i++) begin
      cyc($sformatf("trap_hold%0d", i), 1'b0, (i % 2 == 0) ? RT : LW, 1'b1, 4'd15, E_TRAP);
    end
    cyc("trap_reset", 1'b1, SW, 1'b1, 4'd0, E_RESET);
    cyc("trap_rel",   1'b0, SW, 1'b1, 4'd0, E_FETCH);
    cyc("sw_dec",     1'b0, SW, 1'b1, 4'd1, E_DECODE);
    cyc("sw_adr",     1'b0, SW, 1'b1, 4'd2, E_MEMADR);
    cyc("sw_wr",      1'b0, SW, 1'b1, 4'd5, E_MEMWR);

    // Async reset in the middle of MEMWR, well clear of any clock edge
    #1 reset = 1'b1;
    #1 check("async_rst", 4'd0, E_RESET);
    cyc("rst_held",   1'b1, SW, 1'b1, 4'd0, E_RESET);
    cyc("rst_rel",    1'b0, SW, 1'b1, 4'd0, E_FETCH);
    cyc("post_dec",   1'b0, SW, 1'b1, 4'd1, E_DECODE);
    cyc("post_adr",   1'b0, SW, 1'b1, 4'd2, E_MEMADR);

`ifdef MC_STALL_EN
    cyc("stl_wr0",    1'b0, SW, 1'b0, 4'd5, E_MEMWRW);
    cyc("stl_wr1",    1'b0, SW, 1'b0, 4'd5, E_MEMWRW);
    cyc("stl_wr2",    1'b0, SW, 1'b0, 4'd5, E_MEMWRW);
    cyc("stl_wr3",    1'b0, SW, 1'b1, 4'd5, E_MEMWR);
    cyc("stl_f0",     1'b0, LW, 1'b0, 4'd0, E_RESET);
    cyc("stl_f1",     1'b0, LW, 1'b1, 4'd0, E_FETCH);
    cyc("stl_dec",    1'b0, LW, 1'b1, 4'd1, E_DECODE);
    cyc("stl_adr",    1'b0, LW, 1'b1, 4'd2, E_MEMADR);
    cyc("stl_rd0",    1'b0, LW, 1'b0, 4'd3, E_MEMRD);
    cyc("stl_rd1",    1'b0, LW, 1'b1, 4'd3, E_MEMRD);
    cyc("stl_wb",     1'b0, LW, 1'b1, 4'd4, E_MEMWB);
`else
    cyc("nostl_wr",   1'b0, SW, 1'b0, 4'd5, E_MEMWR);
    cyc("nostl_f",    1'b0, LW, 1'b0, 4'd0, E_FETCH);
    cyc("nostl_dec",  1'b0, LW, 1'b0, 4'd1, E_DECODE);
    cyc("nostl_adr",  1'b0, LW, 1'b0, 4'd2, E_MEMADR);
    cyc("nostl_rd",   1'b0, LW, 1'b0, 4'd3, E_MEMRD);
    cyc("nostl_wb",   1'b0, LW, 1'b0, 4'd4, E_MEMWB);
`endif
    cyc("final_f",    1'b0, RT, 1'b1, 4'd0, E_FETCH);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
